// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD responder: FSM states, command
// bit positions, DDRAM address map constants and address-counter helpers.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEARING,
    ST_BUSY
  } lcd_state_e;

  localparam int CMD_DDRAM_BIT = 7;
  localparam int CMD_CGRAM_BIT = 6;
  localparam int CMD_FUNC_BIT  = 5;
  localparam int CMD_SHIFT_BIT = 4;
  localparam int CMD_DISP_BIT  = 3;
  localparam int CMD_ENTRY_BIT = 2;
  localparam int CMD_HOME_BIT  = 1;
  localparam int CMD_CLEAR_BIT = 0;

  localparam int FUNC_N_BIT   = 3;
  localparam int SHIFT_S_BIT  = 3;
  localparam int SHIFT_R_BIT  = 2;
  localparam int DISP_D_BIT   = 2;
  localparam int DISP_C_BIT   = 1;
  localparam int DISP_B_BIT   = 0;
  localparam int ENTRY_ID_BIT = 1;

  localparam logic [7:0] SPACE_CHAR = 8'h20;
  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE0_LAST = 7'h27;
  localparam logic [6:0] LINE1_LAST = 7'h67;
  localparam int         FILL_LEN   = 32;

  // Visible windows 0x00-0x0F and 0x40-0x4F both have bits 5:4 clear.
  function automatic logic ddram_visible(input logic [6:0] a);
    return (a[5:4] == 2'b00);
  endfunction

  function automatic logic [4:0] ddram_idx(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    logic [6:0] n;
    if (up) begin
      if (a == LINE0_LAST)      n = LINE1_BASE;
      else if (a == LINE1_LAST) n = LINE0_BASE;
      else                      n = a + 7'd1;
    end else begin
      if (a == LINE0_BASE)      n = LINE1_LAST;
      else if (a == LINE1_BASE) n = LINE0_LAST;
      else                      n = a - 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lcd_ddram_buffer.sv
// 32x8 display character store: one write port, two independent registered
// read ports (bus read-back and observer).
module lcd_ddram_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata_a <= r_mem[i_raddr_a];
    o_rdata_b <= r_mem[i_raddr_b];
  end

endmodule

// File: rtl/lcd_responder.sv
// HD44780-style LCD bus responder: synchronizes the initiator bus, decodes
// commands/data on E falling edges and models busy timing and the DDRAM.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 50,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       proto_err,
  output logic [6:0] ac
);

  localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_LEN - 1);

  logic       r_e_p0, r_e_p1, r_e_p2;
  logic       r_rs_p0, r_rs_p1, r_rw_p0, r_rw_p1;
  logic [7:0] r_d_p0, r_d_p1;
  logic       r_rs_lat, r_rw_lat;
  logic [7:0] r_d_lat;

  lcd_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, r_limit;
  logic [6:0]       r_ac;
  logic             r_id, r_cg, r_disp, r_cur, r_blink, r_two, r_perr;

  logic       w_fall, w_busy, w_is_status, w_acc, w_exec, w_cmd, w_is_clear;
  logic       w_wr, w_rd, w_ac_vis, w_fill, w_we;
  logic [4:0] w_ac_idx, w_waddr;
  logic [7:0] w_wdata, w_rdata_a;

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous E for edge
  // detection, and the latches keep rs/rw/data from the last E-high cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_e_p0, r_e_p1, r_e_p2}    <= '0;
      {r_rs_p0, r_rs_p1}          <= '0;
      {r_rw_p0, r_rw_p1}          <= '0;
      {r_d_p0, r_d_p1}            <= '0;
      {r_rs_lat, r_rw_lat}        <= '0;
      r_d_lat                     <= '0;
    end else begin
      r_e_p0  <= lcd_e;       r_e_p1  <= r_e_p0;  r_e_p2 <= r_e_p1;
      r_rs_p0 <= lcd_rs;      r_rs_p1 <= r_rs_p0;
      r_rw_p0 <= lcd_rw;      r_rw_p1 <= r_rw_p0;
      r_d_p0  <= lcd_data_in; r_d_p1  <= r_d_p0;
      if (r_e_p1) begin
        r_rs_lat <= r_rs_p1;
        r_rw_lat <= r_rw_p1;
        r_d_lat  <= r_d_p1;
      end
    end
  end

  // Stage p2: transaction decode on the synchronized E falling edge
  assign w_fall      = r_e_p2 & ~r_e_p1;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_is_status = ~r_rs_lat & r_rw_lat;
  assign w_acc       = w_fall & ~w_busy;
  assign w_exec      = w_acc & ~w_is_status;
  assign w_cmd       = w_exec & ~r_rs_lat & ~r_rw_lat;
  assign w_is_clear  = w_cmd & (r_d_lat == 8'h01);
  assign w_wr        = w_exec & r_rs_lat & ~r_rw_lat;
  assign w_rd        = w_exec & r_rs_lat & r_rw_lat;
  assign w_ac_vis    = ddram_visible(r_ac);
  assign w_ac_idx    = ddram_idx(r_ac);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:     if (w_exec) w_state_nxt = w_is_clear ? ST_CLEARING : ST_BUSY;
      ST_CLEARING: if (r_cnt == FILL_LAST) w_state_nxt = ST_BUSY;
      ST_BUSY:     if (r_cnt == r_limit - CNT_W'(1)) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_CLEARING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CLEARING;
    else     r_state <= w_state_nxt;
  end

  // One counter times both the 32-cycle fill and the total busy window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_limit <= CNT_W'(CLEAR_CYCLES);
    end else if (r_state == ST_IDLE) begin
      if (w_exec) begin
        r_cnt   <= '0;
        r_limit <= w_is_clear ? CNT_W'(CLEAR_CYCLES) : CNT_W'(BUSY_CYCLES);
      end
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ac    <= LINE0_BASE;
      r_id    <= 1'b1;
      r_cg    <= 1'b0;
      r_disp  <= 1'b0;
      r_cur   <= 1'b0;
      r_blink <= 1'b0;
      r_two   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      if (w_fall & w_busy & ~w_is_status) r_perr <= 1'b1;
      if (w_cmd) begin
        if (r_d_lat[CMD_DDRAM_BIT]) begin
          r_ac <= r_d_lat[6:0];
          r_cg <= 1'b0;
        end else if (r_d_lat[CMD_CGRAM_BIT]) begin
          r_cg <= 1'b1;
        end else if (r_d_lat[CMD_FUNC_BIT]) begin
          r_two <= r_d_lat[FUNC_N_BIT];
        end else if (r_d_lat[CMD_SHIFT_BIT]) begin
          if (!r_d_lat[SHIFT_S_BIT]) r_ac <= ac_step(r_ac, r_d_lat[SHIFT_R_BIT]);
        end else if (r_d_lat[CMD_DISP_BIT]) begin
          r_disp  <= r_d_lat[DISP_D_BIT];
          r_cur   <= r_d_lat[DISP_C_BIT];
          r_blink <= r_d_lat[DISP_B_BIT];
        end else if (r_d_lat[CMD_ENTRY_BIT]) begin
          r_id <= r_d_lat[ENTRY_ID_BIT];
        end else if (r_d_lat[CMD_HOME_BIT]) begin
          r_ac <= LINE0_BASE;
        end else if (r_d_lat[CMD_CLEAR_BIT]) begin
          r_ac <= LINE0_BASE;
          r_id <= 1'b1;
        end
      end
      if ((w_wr & ~r_cg) | w_rd) r_ac <= ac_step(r_ac, r_id);
    end
  end

  // Fill owns the write port while clearing; the bus is locked out then anyway.
  assign w_fill  = (r_state == ST_CLEARING);
  assign w_we    = w_fill | (w_wr & ~r_cg & w_ac_vis);
  assign w_waddr = w_fill ? r_cnt[4:0] : w_ac_idx;
  assign w_wdata = w_fill ? SPACE_CHAR : r_d_lat;

  lcd_ddram_buffer #(.DATA_W(8), .ADDR_W(5)) u_ddram (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_ac_idx),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (rd_addr),
    .o_rdata_b (rd_char)
  );

  always_comb begin
    lcd_data_oe  = r_e_p1 & r_rw_p1;
    lcd_data_out = 8'h00;
    if (lcd_data_oe) begin
      if (r_rs_p1) lcd_data_out = w_ac_vis ? w_rdata_a : SPACE_CHAR;
      else         lcd_data_out = {w_busy, r_ac};
    end
  end

  assign busy       = w_busy;
  assign ac         = r_ac;
  assign display_on = r_disp;
  assign cursor_on  = r_cur;
  assign blink_on   = r_blink;
  assign two_line   = r_two;
  assign proto_err  = r_perr;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: reset/clear, writes, address wrap,
// flag commands, read-back, busy rejection and reset during clear.
module tb_lcd_responder;

  localparam int BUSY_C  = 24;
  localparam int CLEAR_C = 96;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] lcd_data_out, rd_char;
  logic       lcd_data_oe, busy, display_on, cursor_on, blink_on, two_line, proto_err;
  logic [6:0] ac;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lcd_responder #(.BUSY_CYCLES(BUSY_C), .CLEAR_CYCLES(CLEAR_C)) dut (
    .clk          (clk),
    .rst          (rst),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_e        (lcd_e),
    .lcd_data_in  (lcd_data_in),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .rd_addr      (rd_addr),
    .rd_char      (rd_char),
    .busy         (busy),
    .display_on   (display_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .two_line     (two_line),
    .proto_err    (proto_err),
    .ac           (ac)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    n_tests++;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%0b still set, want 0", tag, busy);
    end
  endtask

  task automatic bus(input logic rs, input logic [7:0] d, input string tag);
    pulse(rs, 1'b0, d);
    repeat (4) @(negedge clk);
    wait_idle(tag);
  endtask

  task automatic peek(input logic [4:0] a, output logic [7:0] v);
    rd_addr = a;
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (ac !== 7'h00) begin n_fail++; $display("FAIL rst_ac: got %h want 00", ac); end
    n_tests++;
    if ({display_on, cursor_on, blink_on, two_line} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_flags: got %b want 0000", {display_on, cursor_on, blink_on, two_line});
    end
    n_tests++;
    if ({proto_err, lcd_data_oe, lcd_data_out} !== 10'h000) begin
      n_fail++; $display("FAIL rst_bus: got perr=%b oe=%b out=%h want 0/0/00", proto_err, lcd_data_oe, lcd_data_out);
    end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", busy); end
    repeat (CLEAR_C - 1) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy_end: got %b want 1", busy); end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy_done: got %b want 0", busy); end
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      n_tests++;
      if (v !== 8'h20) begin n_fail++; $display("FAIL rst_fill[%0d]: got %h want 20", i, v); end
    end
  endtask

  task automatic test_write_hi;
    logic [7:0] v;
    bus(1'b0, 8'h80, "hi_cmd");
    bus(1'b1, 8'h48, "hi_H");
    bus(1'b1, 8'h69, "hi_i");
    n_tests++;
    if (ac !== 7'h02) begin n_fail++; $display("FAIL hi_ac: got %h want 02", ac); end
    peek(5'h00, v);
    n_tests++;
    if (v !== 8'h48) begin n_fail++; $display("FAIL hi_buf0: got %h want 48", v); end
    peek(5'h01, v);
    n_tests++;
    if (v !== 8'h69) begin n_fail++; $display("FAIL hi_buf1: got %h want 69", v); end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    bus(1'b0, 8'hA7, "wrap_a7");
    bus(1'b1, 8'h58, "wrap_X");
    n_tests++;
    if (ac !== 7'h40) begin n_fail++; $display("FAIL wrap_27: got %h want 40", ac); end
    peek(5'h07, v);
    n_tests++;
    if (v !== 8'h20) begin n_fail++; $display("FAIL wrap_X_hidden: got %h want 20", v); end
    bus(1'b0, 8'hE7, "wrap_e7");
    bus(1'b1, 8'h59, "wrap_Y");
    n_tests++;
    if (ac !== 7'h00) begin n_fail++; $display("FAIL wrap_67: got %h want 00", ac); end
    peek(5'h17, v);
    n_tests++;
    if (v !== 8'h20) begin n_fail++; $display("FAIL wrap_Y_hidden: got %h want 20", v); end
    peek(5'h00, v);
    n_tests++;
    if (v !== 8'h48) begin n_fail++; $display("FAIL wrap_buf0: got %h want 48", v); end
  endtask

  task automatic test_decrement;
    logic [7:0] v;
    bus(1'b0, 8'h04, "dec_entry");
    bus(1'b0, 8'hC0, "dec_c0");
    bus(1'b1, 8'h5A, "dec_Z");
    peek(5'h10, v);
    n_tests++;
    if (v !== 8'h5A) begin n_fail++; $display("FAIL dec_buf10: got %h want 5a", v); end
    n_tests++;
    if (ac !== 7'h27) begin n_fail++; $display("FAIL dec_ac: got %h want 27", ac); end
    bus(1'b0, 8'h06, "dec_restore");
  endtask

  task automatic test_flags_shift;
    bus(1'b0, 8'h0F, "disp_0f");
    n_tests++;
    if ({display_on, cursor_on, blink_on} !== 3'b111) begin
      n_fail++; $display("FAIL disp_0f: got %b want 111", {display_on, cursor_on, blink_on});
    end
    bus(1'b0, 8'h0D, "disp_0d");
    n_tests++;
    if ({display_on, cursor_on, blink_on} !== 3'b101) begin
      n_fail++; $display("FAIL disp_0d: got %b want 101", {display_on, cursor_on, blink_on});
    end
    bus(1'b0, 8'h38, "func_38");
    n_tests++;
    if (two_line !== 1'b1) begin n_fail++; $display("FAIL func_two_line: got %b want 1", two_line); end
    bus(1'b0, 8'h14, "shift_r");
    n_tests++;
    if (ac !== 7'h40) begin n_fail++; $display("FAIL shift_right: got %h want 40", ac); end
    bus(1'b0, 8'h10, "shift_l");
    n_tests++;
    if (ac !== 7'h27) begin n_fail++; $display("FAIL shift_left: got %h want 27", ac); end
    bus(1'b0, 8'h02, "home");
    n_tests++;
    if (ac !== 7'h00) begin n_fail++; $display("FAIL home_ac: got %h want 00", ac); end
  endtask

  task automatic test_cgram;
    logic [7:0] v;
    bus(1'b0, 8'h40, "cg_set");
    bus(1'b1, 8'h43, "cg_data");
    n_tests++;
    if (ac !== 7'h00) begin n_fail++; $display("FAIL cg_ac: got %h want 00", ac); end
    peek(5'h00, v);
    n_tests++;
    if (v !== 8'h48) begin n_fail++; $display("FAIL cg_buf0: got %h want 48", v); end
    bus(1'b0, 8'h80, "cg_exit");
  endtask

  task automatic test_data_read;
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_data_in = 8'h00; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({lcd_data_oe, lcd_data_out} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL idle_status: got oe=%b out=%h want 1/00", lcd_data_oe, lcd_data_out);
    end
    @(negedge clk);
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL status_no_busy: got %b want 0", busy); end
    @(negedge clk);
    lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({lcd_data_oe, lcd_data_out} !== {1'b1, 8'h48}) begin
      n_fail++; $display("FAIL data_read: got oe=%b out=%h want 1/48", lcd_data_oe, lcd_data_out);
    end
    @(negedge clk);
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    wait_idle("rd");
    n_tests++;
    if (ac !== 7'h01) begin n_fail++; $display("FAIL read_ac: got %h want 01", ac); end
  endtask

  task automatic test_busy;
    logic [7:0] v;
    bus(1'b0, 8'h85, "busy_setac");
    pulse(1'b1, 1'b0, 8'h51);
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({lcd_data_oe, lcd_data_out} !== {1'b1, 8'h86}) begin
      n_fail++; $display("FAIL busy_status: got oe=%b out=%h want 1/86", lcd_data_oe, lcd_data_out);
    end
    @(negedge clk);
    lcd_e = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (lcd_data_oe !== 1'b0) begin n_fail++; $display("FAIL status_oe_off: got %b want 0", lcd_data_oe); end
    n_tests++;
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL status_no_err: got %b want 0", proto_err); end
    @(negedge clk);
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data_in = 8'h52; lcd_e = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (lcd_data_oe !== 1'b0) begin n_fail++; $display("FAIL write_oe: got %b want 0", lcd_data_oe); end
    repeat (2) @(negedge clk);
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    wait_idle("busy");
    n_tests++;
    if (proto_err !== 1'b1) begin n_fail++; $display("FAIL busy_err: got %b want 1", proto_err); end
    n_tests++;
    if (ac !== 7'h06) begin n_fail++; $display("FAIL busy_ac: got %h want 06", ac); end
    peek(5'h05, v);
    n_tests++;
    if (v !== 8'h51) begin n_fail++; $display("FAIL busy_buf5: got %h want 51", v); end
    peek(5'h06, v);
    n_tests++;
    if (v !== 8'h20) begin n_fail++; $display("FAIL busy_buf6: got %h want 20", v); end
  endtask

  task automatic test_mid_clear;
    logic [7:0] v;
    bit seen = 1'b0;
    pulse(1'b0, 1'b0, 8'h01);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL clear_start: busy=%b want 1", busy); end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({ac, display_on, two_line, proto_err} !== 10'h000) begin
      n_fail++; $display("FAIL midrst_state: got ac=%h d=%b n=%b perr=%b want 00/0/0/0", ac, display_on, two_line, proto_err);
    end
    repeat (32) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      n_tests++;
      if (v !== 8'h20) begin n_fail++; $display("FAIL midrst_fill[%0d]: got %h want 20", i, v); end
    end
    repeat (CLEAR_C - 1 - 64) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_end: got %b want 1", busy); end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_done: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write_hi();
    test_wrap();
    test_decrement();
    test_flags_shift();
    test_cgram();
    test_data_read();
    test_busy();
    test_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 50: busy duration in clk cycles after any executed command or data access.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 1600: total busy duration in clk cycles after a clear command, which SHALL be at least 33.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 lcd_rs, lcd_rw, lcd_e  in  1 each  HD44780-style bus control from the initiator.
REQ-006 lcd_data_in  in  8  bus data from the initiator.
REQ-007 lcd_data_out  out  8  read-back data; lcd_data_oe  out  1  drive-enable for read-back.
REQ-008 rd_addr  in  5  observer index: bit4 = line, bits3:0 = column; rd_char  out  8  registered character at rd_addr.
REQ-009 busy, display_on, cursor_on, blink_on, two_line, proto_err  out  1 each; ac  out  7  address counter.

Function
REQ-010 SHALL pass lcd_e, lcd_rs, lcd_rw and lcd_data_in through 2-FF synchronizers; a transaction is a falling edge of synchronized E, using rs/rw/data sampled in the last cycle E was high.
REQ-011 Each transaction SHALL take effect exactly 1 cycle after edge detection (ac, flags, buffer, busy updated together).
REQ-012 SHALL hold a 32x8 display buffer; a DDRAM address is visible iff it is in 0x00-0x0F (line 0) or 0x40-0x4F (line 1); the buffer index is {addr[6], addr[3:0]}.
REQ-013 ac SHALL advance by +1 when I/D=1 and -1 when I/D=0, wrapping 0x27->0x40, 0x67->0x00, 0x00->0x67 (decrement), 0x40->0x27 (decrement).
REQ-014 RS=0 RW=0 command decode by highest set bit:
- 0x01 clear: fill buffer with 0x20 over 32 cycles, ac=0, I/D=1.
- 0x02/0x03 home: ac=0.
- 000001xx entry mode: I/D=bit1; shift bit stored, no effect.
- 00001DCB: display_on=D, cursor_on=C, blink_on=B.
- 0001SRxx: if S=0, ac moves +1 when R=1 else -1 (REQ-013 wrap); S=1 no effect.
- 001xNxxx function set: two_line=N.
- 01xxxxxx set CGRAM address: cg_mode=1.
- 1aaaaaaa set DDRAM address: ac=aaaaaaa, cg_mode=0.
REQ-015 RS=1 RW=0 data write: if cg_mode=0 and ac visible, buffer[idx]=data; ac advances regardless; if cg_mode=1, data is discarded and ac is unchanged.
REQ-016 RS=0 RW=1 status read: while synchronized E=1, lcd_data_oe=1 and lcd_data_out={busy, ac}; no state change and busy not restarted.
REQ-017 RS=1 RW=1 data read: while E=1, drive buffer[idx] (0x20 if ac not visible); ac advances on the falling edge.
REQ-018 lcd_data_oe SHALL be 0 whenever RW=0 or E=0.
REQ-019 Control FSM states IDLE, CLEARING, BUSY:
- IDLE->CLEARING on clear.
- IDLE->BUSY on any other executed transaction except a status read.
- CLEARING->BUSY after 32 fill cycles with the counter continuing to CLEAR_CYCLES.
- BUSY->IDLE when the counter expires.
REQ-020 busy=1 in CLEARING and BUSY.
REQ-021 A non-status transaction while busy=1 SHALL be ignored and SHALL set the sticky proto_err; a status read while busy is legal.
REQ-022 An E falling edge coincident with counter expiry SHALL be treated as busy (rejected).
REQ-023 rd_char SHALL equal buffer[rd_addr] 1 cycle after rd_addr is applied; the observer port never conflicts with the bus side.

Reset
REQ-024 On rst:
- ac=0, I/D=1, cg_mode=0.
- display_on, cursor_on, blink_on, two_line=0.
- proto_err=0, lcd_data_oe=0, lcd_data_out=0.
- synchronizers cleared.
- FSM enters CLEARING, so the buffer reads all 0x20 after 32 cycles.
REQ-025 rst asserted mid-clear or mid-busy SHALL restart the clear sequence from index 0.

Structure
REQ-026 Shared package lcd_pkg SHALL hold: FSM state enum, command bit positions, SPACE_CHAR=0x20, line base addresses 0x00/0x40, wrap bounds 0x27/0x67.
REQ-027 SHALL instantiate one sub-module lcd_ddram_buffer (32x8, one write port, two registered read ports).

Verification
REQ-028 Reset then wait 32 cycles -> all rd_char=0x20, busy=1 until CLEAR_CYCLES, ac=0.
REQ-029 Write 0x80 then data 'H','i' -> rd_addr 0x00='H', 0x01='i', ac=0x02.
REQ-030 Write 0xA7 then data 'X' -> ac=0x40, nothing visible written; then 0xE7, 'Y' -> ac=0x00.
REQ-031 Write 0x04 (I/D=0), then 0xC0, 'Z' -> rd_addr 0x10='Z', ac=0x27.
REQ-032 Issue data write during BUSY -> buffer unchanged, proto_err=1; status read during BUSY -> lcd_data_out={1,ac}, lcd_data_oe=1 only while E=1.
REQ-033 Assert rst at clear fill index 10 -> clear restarts at index 0, all entries 0x20 after 32 cycles.
